// File: rtl/mem_dma.sv
// Bus-initiator DMA engine: copies or fills a block of 32-bit words over the native valid/ready memory bus.
// One outstanding request at a time, with a gap cycle between transactions and a per-request timeout abort.
module mem_dma #(
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned LENWIDTH  = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDRWIDTH-1:0] src_addr,
    input  logic [ADDRWIDTH-1:0] dst_addr,
    input  logic [LENWIDTH-1:0]  length,
    input  logic [31:0]          fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 mem_valid,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
);
    localparam int unsigned          TMO_W      = 16;
    localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDRWIDTH-1:0] WORD_STEP  = ADDRWIDTH'(4);
    localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ~ADDRWIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ADDRWIDTH-1:0]   src_q, src_d;
    logic [ADDRWIDTH-1:0]   dst_q, dst_d;
    logic [LENWIDTH-1:0]    remain_q, remain_d;
    logic [31:0]            fill_q, fill_d;
    logic [31:0]            buf_q, buf_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   abort_d;

    logic                   valid_d;
    logic [ADDRWIDTH-1:0]   addr_d;
    logic [31:0]            wdata_d;
    logic [3:0]             wstrb_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   error_d;

    logic                   hs_c;
    logic                   tmo_hit_c;

    assign hs_c      = mem_valid & mem_ready;
    // The TIMEOUT-th waiting cycle aborts even if ready shows up in it.
    assign tmo_hit_c = (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfer context registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            remain_q <= '0;
            fill_q   <= '0;
            buf_q    <= '0;
            tmo_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            remain_q <= remain_d;
            fill_q   <= fill_d;
            buf_q    <= buf_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        remain_d = remain_q;
        fill_d   = fill_q;
        buf_d    = buf_q;
        tmo_d    = tmo_q;
        abort_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    src_d    = src_addr & ALIGN_MASK;
                    dst_d    = dst_addr & ALIGN_MASK;
                    remain_d = length;
                    fill_d   = fill_data;
                    tmo_d    = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (tmo_hit_c) begin
                    state_d = S_DONE;
                    abort_d = 1'b1;
                end else if (hs_c) begin
                    buf_d   = mem_rdata;
                    src_d   = src_q + WORD_STEP;
                    state_d = S_RD_GAP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RD_GAP: begin
                tmo_d   = '0;
                state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (tmo_hit_c) begin
                    state_d = S_DONE;
                    abort_d = 1'b1;
                end else if (hs_c) begin
                    dst_d    = dst_q + WORD_STEP;
                    remain_d = remain_q - LENWIDTH'(1);
                    if (remain_q == LENWIDTH'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WR_GAP;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WR_GAP: begin
                tmo_d   = '0;
                state_d = mode_q ? S_WR_REQ : S_RD_REQ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every bus/status output comes straight from a flop
    always_comb begin
        valid_d = 1'b0;
        wstrb_d = 4'b0000;
        addr_d  = dst_d;
        wdata_d = mode_d ? fill_d : buf_d;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        error_d = abort_d;
        case (state_d)
            S_RD_REQ: begin
                valid_d = 1'b1;
                addr_d  = src_d;
            end
            S_WR_REQ: begin
                valid_d = 1'b1;
                wstrb_d = 4'b1111;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_valid <= valid_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wstrb <= wstrb_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: directed and random copy/fill transfers against a word-level
// reference model, plus timeout abort and mid-transfer reset.
module tb_mem_dma;
    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 16;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic [31:0]   fill_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_dma #(.ADDRWIDTH(AW), .LENWIDTH(LW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // Responder memory (1024 words, aliased by address bits [11:2]) and bus monitor
    logic [31:0] mem      [0:1023];
    logic [31:0] init_mem [0:1023];
    logic [31:0] mdl      [0:1023];
    logic        load     = 1'b0;
    logic        resp_en  = 1'b1;
    int          resp_lat = 1;
    logic        ready_r  = 1'b0;
    int          vcnt     = 0;
    logic [31:0] log_addr [$];
    logic [3:0]  log_strb [$];
    logic [31:0] log_data [$];
    int          gap_err  = 0;
    int          stab_err = 0;
    logic        prev_hs  = 1'b0;
    logic        prev_valid = 1'b0;
    logic [67:0] prev_req = '0;

    assign mem_ready = ready_r;
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_mem[i];
        end else if (mem_valid && mem_ready && mem_wstrb == 4'hF) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
        if (mem_valid && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_strb.push_back(mem_wstrb);
            log_data.push_back(mem_wstrb == 4'hF ? mem_wdata : mem_rdata);
            ready_r <= 1'b0;
            vcnt    <= 0;
        end else if (mem_valid) begin
            vcnt    <= vcnt + 1;
            ready_r <= resp_en && (vcnt + 1 >= resp_lat);
        end else begin
            ready_r <= 1'b0;
            vcnt    <= 0;
        end
        if (prev_hs && mem_valid) gap_err <= gap_err + 1;
        if (prev_valid && !prev_hs && mem_valid && ({mem_addr, mem_wdata, mem_wstrb} !== prev_req))
            stab_err <= stab_err + 1;
        prev_hs    <= mem_valid && mem_ready;
        prev_valid <= mem_valid;
        prev_req   <= {mem_addr, mem_wdata, mem_wstrb};
    end

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transfer: build the expected bus trace and memory image from word-level rules, then run and compare.
    task automatic run_xfer(input string tag, input logic m, input logic [31:0] s, input logic [31:0] d,
                            input int len, input logic [31:0] fd, input int lat);
        logic [31:0] ea [$];
        logic [3:0]  es [$];
        logic [31:0] ed [$];
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] w;
        int          base;
        int          seen_at;
        int          exp_cyc;
        int          nbad;
        int          ngot;
        resp_lat = lat;
        for (int i = 0; i < 1024; i++) mdl[i] = mem[i];
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < len; i++) begin
            if (m) begin
                w = fd;
            end else begin
                w = mdl[sa[11:2]];
                ea.push_back(sa);
                es.push_back(4'h0);
                ed.push_back(w);
                sa = sa + 32'd4;
            end
            ea.push_back(da);
            es.push_back(4'hF);
            ed.push_back(w);
            mdl[da[11:2]] = w;
            da = da + 32'd4;
        end
        // Each word costs (lat+1) request cycles plus one gap per transaction; the final gap is replaced by DONE.
        if (len == 0)  exp_cyc = 0;
        else if (m)    exp_cyc = len * (lat + 2) - 1;
        else           exp_cyc = len * (2 * lat + 4) - 1;
        base = log_addr.size();

        @(negedge clk);
        start     = 1'b1;
        mode      = m;
        src_addr  = s;
        dst_addr  = d;
        length    = LW'(len);
        fill_data = fd;
        @(posedge clk);
        seen_at = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen_at = i;
                break;
            end
            @(posedge clk);
        end
        check({tag, " done_cycle"}, 64'(seen_at), 64'(exp_cyc));
        check({tag, " busy_at_done"}, busy, 1'b1);
        check({tag, " error_at_done"}, error, 1'b0);
        check({tag, " valid_at_done"}, mem_valid, 1'b0);
        @(negedge clk);
        check({tag, " idle_after"}, {busy, done, error}, 3'b000);

        ngot = log_addr.size() - base;
        check({tag, " txn_count"}, 64'(ngot), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < ngot; i++) begin
            check({tag, $sformatf(" addr[%0d]", i)}, log_addr[base + i], ea[i]);
            check({tag, $sformatf(" strb[%0d]", i)}, log_strb[base + i], es[i]);
            check({tag, $sformatf(" data[%0d]", i)}, log_data[base + i], ed[i]);
        end
        nbad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== mdl[i]) nbad++;
        check({tag, " mem_image"}, 64'(nbad), 64'd0);
        check({tag, " gap_rule"}, 64'(gap_err), 64'd0);
        check({tag, " req_stable"}, 64'(stab_err), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_cnt;
        int seen_at;
        int hits;
        bit found;
        reset_n   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        fill_data = '0;
        for (int i = 0; i < 1024; i++) init_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) init_mem[i] = 32'h1111_1111 * 32'(i + 1);
        load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset status", {busy, done, error}, 3'b000);
        check("reset valid", mem_valid, 1'b0);
        check("reset bus", {mem_addr, mem_wdata, mem_wstrb}, 68'd0);
        load    = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle quiet", {busy, done, error, mem_valid}, 4'b0000);

        run_xfer("len0", 1'b0, 32'h40, 32'h80, 0, 32'h0, 1);
        run_xfer("fill", 1'b1, 32'h0, 32'h100, 4, 32'hDEAD_BEEF, 1);
        run_xfer("copy", 1'b0, 32'h0, 32'h200, 4, 32'h0, 1);
        run_xfer("wrap", 1'b0, 32'h3, 32'hFFFF_FFFC, 2, 32'h0, 1);
        for (int k = 0; k < 8; k++) begin
            run_xfer($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), $urandom, $urandom,
                     int'($urandom_range(0, 8)), $urandom, int'($urandom_range(1, 3)));
        end

        // Timeout: responder never answers; a start pulse mid-transfer must be ignored.
        resp_en = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        mode     = 1'b0;
        src_addr = 32'h10;
        dst_addr = 32'h300;
        length   = LW'(3);
        @(posedge clk);
        valid_cnt = 0;
        seen_at   = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin
                mode   = 1'b1;
                length = '0;
            end
            if (done) begin
                seen_at = i;
                break;
            end
            if (mem_valid) valid_cnt++;
            @(posedge clk);
        end
        start = 1'b0;
        check("tmo valid_cycles", 64'(valid_cnt), 64'(TMO));
        check("tmo done_cycle", 64'(seen_at), 64'(TMO));
        check("tmo done_error", {done, error, busy, mem_valid}, 4'b1110);
        @(negedge clk);
        check("tmo after", {busy, done, error, mem_valid}, 4'b0000);
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || mem_valid) hits++;
        end
        check("tmo ignored_start", 64'(hits), 64'd0);
        resp_en = 1'b1;

        // Reset during the first write request of a copy.
        resp_lat = 1;
        @(negedge clk);
        start    = 1'b1;
        mode     = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h300;
        length   = LW'(4);
        @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_valid && mem_wstrb == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        check("rst found_wr_req", found, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst drops", {mem_valid, busy, done, error}, 4'b0000);
        reset_n = 1'b1;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || mem_valid) hits++;
        end
        check("rst no_done", 64'(hits), 64'd0);
        run_xfer("after_rst", 1'b0, 32'h20, 32'h380, 3, 32'h0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Bus-initiator DMA engine that drives the native memory handshake (valid/addr/wdata/wstrb out, ready/rdata in) that the on-chip SRAM and peripherals respond to.
- Copies a block of 32-bit words from a source to a destination, or fills a block with a constant word.
- Sits beside the CPU on the memory bus behind an arbiter and is controlled by a simple start/busy/done interface.
- A per-transaction timeout aborts the transfer if a responder never asserts ready.

Parameters:
ADDRWIDTH, 32, width of the byte address on the bus.
LENWIDTH, 16, width of the word-count input.
TIMEOUT, 255, maximum cycles mem_valid may wait for mem_ready before aborting (1..2^16-1).

Ports:
clk  input  1  system clock; everything on rising edge.
reset_n  input  1  synchronous, active-low reset.
start  input  1  one-cycle request; accepted only in IDLE.
mode  input  1  0 = copy, 1 = fill.
src_addr  input  ADDRWIDTH  source byte address (copy only).
dst_addr  input  ADDRWIDTH  destination byte address.
length  input  LENWIDTH  number of 32-bit words to transfer.
fill_data  input  32  word written in fill mode.
busy  output  1  high while a transfer is in progress.
done  output  1  one-cycle pulse at end of transfer (normal or aborted).
error  output  1  one-cycle pulse, coincident with done, on timeout abort.
mem_valid  output  1  bus request.
mem_addr  output  ADDRWIDTH  word-aligned byte address.
mem_wdata  output  32  write data.
mem_wstrb  output  4  byte enables; 4'b0000 = read, 4'b1111 = write.
mem_ready  input  1  responder completion.
mem_rdata  input  32  read data, valid when mem_ready is high.

Behaviour:
- Reset: synchronous on reset_n low. Returns to IDLE and forces mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done and error to 0 on that edge.
- Reset mid-transfer drops mem_valid on the next edge. No done pulse is generated.
- Start sampling: start, mode, addresses, length and fill_data are sampled on the edge where start=1 in IDLE.
- Addresses are latched with bits [1:0] forced to 0.
- start while busy is ignored.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE.
  - IDLE: start with length=0 goes to DONE. Otherwise copy goes to RD_REQ and fill goes to WR_REQ.
  - RD_REQ: mem_valid=1, mem_wstrb=0, mem_addr=src. On mem_valid&mem_ready, capture mem_rdata into the data buffer, src+=4, go to RD_GAP.
  - RD_GAP: mem_valid=0 for one cycle, then WR_REQ.
  - WR_REQ: mem_valid=1, mem_wstrb=4'b1111, mem_addr=dst, mem_wdata = data buffer (copy) or fill_data (fill). On handshake, dst+=4 and remaining-=1.
    - If remaining becomes 0, go to DONE.
    - Else go to WR_GAP.
  - WR_GAP: mem_valid=0 for one cycle, then RD_REQ (copy) or WR_REQ (fill).
  - DONE: mem_valid=0, done=1 for exactly one cycle, then IDLE.
- Gap rule: mem_valid is low for at least one cycle between consecutive transactions. Responders register ready from select, so ready lags by one cycle and stays high while valid is held.
- Request stability: while mem_valid=1, mem_addr, mem_wdata and mem_wstrb are held stable until the handshake cycle.
- Address arithmetic: increments wrap modulo 2^ADDRWIDTH.
- busy: 1 in every state except IDLE, including the DONE cycle.
- Timeout: a counter clears on entry to RD_REQ/WR_REQ and increments each cycle mem_valid=1 and mem_ready=0. When it equals TIMEOUT, the engine drops mem_valid and goes to DONE with error=1 alongside done. A ready arriving in that same cycle is ignored.
- Latency (responder asserting ready on the second valid cycle), with c1 = first mem_valid cycle (the cycle after start is accepted):
  - copy of N words: done in cycle c1+6N-1.
  - fill of N words: done in cycle c1+3N-1.
  - length=0: done in the cycle after start is accepted, with no bus activity.

Test Plan:
- Reset then idle: all outputs 0; start with length=0 → done=1 and busy=1 exactly one cycle after start, mem_valid never rises.
- Fill: dst=0x100, length=4, fill_data=0xDEADBEEF, one-cycle-ready SRAM model → writes to 0x100,0x104,0x108,0x10C with wstrb=4'hF; done 12 cycles after first mem_valid-1 (c1+11); memory holds pattern.
- Copy: src=0x000 preloaded 0x11111111..0x44444444, dst=0x200, length=4 → alternating read/write, gap cycle between every transaction, done at c1+23, dst words match.
- Misaligned/wrap: src=0x003 → first read at 0x000; dst=0xFFFFFFFC length=2 → second write at 0x00000000.
- Timeout: TIMEOUT=8, mem_ready tied 0 → mem_valid high 8 cycles, then done=1 and error=1 same cycle, busy low next cycle; start during busy ignored.
- Reset mid-copy (during WR_REQ, reset_n low 1 cycle) → mem_valid=0 next edge, no done pulse, new start afterwards completes normally.
